// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: main FSM, NZCV flags, condition check and datapath control decode.
// Defining ARM_MCTRL_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module arm_multicycle_ctrl #(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_ready,
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    input  logic [3:0]         rd,
    input  logic [3:0]         cond,
    input  logic [3:0]         alu_flags,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_control,
    output logic [1:0]         imm_src,
    output logic [1:0]         reg_src,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state_o
`ifdef ARM_MCTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instr_cnt
`endif
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    if (STATE_W < 4 || CNT_W < 1) begin : gBadParams
        $error("arm_multicycle_ctrl: STATE_W must be >= 4 and CNT_W >= 1");
    end

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic [3:0] execFlags_q, execFlags_d;
    logic       badCmd_q, badCmd_d;

    logic       flagN, flagZ, flagC, flagV;
    logic       condBase, condEx;
    logic       cmdBad;
    logic [1:0] cmdCtl;
    logic       aluWbWrite, rdIsPc;

    assign {flagN, flagZ, flagC, flagV} = flags_q;

    // ARM conditions come in pairs: cond[3:1] picks the test, cond[0] inverts it; 1111 never executes.
    always_comb begin : condCheck
        condBase = 1'b1;
        case (cond[3:1])
            3'b000:  condBase = flagZ;
            3'b001:  condBase = flagC;
            3'b010:  condBase = flagN;
            3'b011:  condBase = flagV;
            3'b100:  condBase = flagC & ~flagZ;
            3'b101:  condBase = (flagN == flagV);
            3'b110:  condBase = ~flagZ & (flagN == flagV);
            default: condBase = 1'b1;
        endcase
        condEx = (cond == 4'b1111) ? 1'b0 : (condBase ^ cond[0]);
    end

    always_comb begin : cmdDecode
        cmdCtl = ALU_ADD;
        cmdBad = 1'b0;
        case (funct[4:1])
            4'b0100: cmdCtl = ALU_ADD;
            4'b0010: cmdCtl = ALU_SUB;
            4'b0000: cmdCtl = ALU_AND;
            4'b1100: cmdCtl = ALU_ORR;
            default: cmdBad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin : stateReg
        if (rst) begin
            state_q     <= FETCH;
            flags_q     <= 4'b0000;
            execFlags_q <= 4'b0000;
            badCmd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            execFlags_q <= execFlags_d;
            badCmd_q    <= badCmd_d;
        end
    end

    always_comb begin : nextState
        state_d = state_q;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (op)
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    2'b00:   state_d = funct[5] ? EXECI : EXECR;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (!condEx || mem_ready) state_d = FETCH;
            EXECR:  state_d = ALUWB;
            EXECI:  state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // The EXEC cycle captures the ALU flags and the cmd legality so ALUWB can commit or suppress them.
    always_comb begin : flagsNext
        flags_d     = flags_q;
        execFlags_d = execFlags_q;
        badCmd_d    = badCmd_q;
        if (state_q == EXECR || state_q == EXECI) begin
            execFlags_d = alu_flags;
            badCmd_d    = cmdBad;
        end
        if (state_q == ALUWB && funct[0] && aluWbWrite) begin
            flags_d = execFlags_q;
        end
    end

    assign aluWbWrite = condEx && !badCmd_q;
    assign rdIsPc     = (rd == 4'd15);

    always_comb begin : outputDecode
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_control   = ALU_ADD;
        illegal_instr = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                illegal_instr = (op == 2'b11);
            end
            MEMADR: alu_src_b = 2'b01;
            MEMRD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = condEx;
            end
            MEMWR: begin
                adr_src   = 1'b1;
                mem_write = condEx;
            end
            EXECR: begin
                alu_control   = cmdCtl;
                illegal_instr = cmdBad;
            end
            EXECI: begin
                alu_src_b     = 2'b01;
                alu_control   = cmdCtl;
                illegal_instr = cmdBad;
            end
            ALUWB: begin
                // Operand select stays as in EXEC so ALUResult is stable during writeback.
                alu_src_b = funct[5] ? 2'b01 : 2'b00;
                reg_write = aluWbWrite && !rdIsPc;
                pc_write  = aluWbWrite && rdIsPc;
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = condEx;
            end
            default: ;
        endcase
        if (rst) begin
            pc_write      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            illegal_instr = 1'b0;
        end
    end

    assign imm_src = op;
    assign reg_src = {op == 2'b01, op == 2'b10};
    assign state_o = STATE_W'(state_q);

`ifdef ARM_MCTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycleCnt_q, instrCnt_q;

    always_ff @(posedge clk) begin : perfCounters
        if (rst) begin
            cycleCnt_q <= '0;
            instrCnt_q <= '0;
        end else begin
            cycleCnt_q <= cycleCnt_q + CNT_W'(1);
            if (state_q != FETCH && state_d == FETCH) begin
                instrCnt_q <= instrCnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt = cycleCnt_q;
    assign instr_cnt = instrCnt_q;
`endif

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Randomized scoreboard bench for arm_multicycle_ctrl: an instruction-level model queues the
// expected per-cycle control outputs and a monitor compares them against the DUT.
module tb_arm_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] state;
        logic       pcW;
        logic       regW;
        logic       memW;
        logic       irW;
        logic       ill;
        logic       adrSrc;
        logic       srcA;
        logic [1:0] resSrc;
        logic [1:0] srcB;
        logic [1:0] aluCtl;
        logic [1:0] immSrc;
        logic [1:0] regSrc;
    } exp_t;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ready;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_b, alu_control, imm_src, reg_src;
    logic       alu_src_a, illegal_instr;
    logic [3:0] state_o;

    exp_t       expQ[$];
    logic [3:0] mFlags;
    int         checks = 0;
    int         errors = 0;

    arm_multicycle_ctrl #(.STATE_W(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .op(op), .funct(funct), .rd(rd),
        .cond(cond), .alu_flags(alu_flags), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .reg_src(reg_src),
        .illegal_instr(illegal_instr), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rnib();
        return 4'($urandom_range(0, 15));
    endfunction

    // Full ARM condition table, flags ordered NZCV.
    function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e        = '0;
        e.state  = st;
        e.immSrc = op;
        e.regSrc = {op == 2'b01, op == 2'b10};
        return e;
    endfunction

    task automatic applyStimulus(input logic r, input logic ready, input logic [3:0] af, input exp_t e);
        rst       = r;
        mem_ready = ready;
        alu_flags = af;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t want);
        exp_t got;
        got.state  = state_o;
        got.pcW    = pc_write;
        got.regW   = reg_write;
        got.memW   = mem_write;
        got.irW    = ir_write;
        got.ill    = illegal_instr;
        got.adrSrc = adr_src;
        got.srcA   = alu_src_a;
        got.resSrc = result_src;
        got.srcB   = alu_src_b;
        got.aluCtl = alu_control;
        got.immSrc = imm_src;
        got.regSrc = reg_src;
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL ctrl_outputs t=%0t state got %0d want %0d | pc/reg/mem/ir/ill got %b%b%b%b%b want %b%b%b%b%b | vector got %h want %h",
                     $time, got.state, want.state, got.pcW, got.regW, got.memW, got.irW, got.ill,
                     want.pcW, want.regW, want.memW, want.irW, want.ill, got, want);
        end
    endtask

    task automatic doFetch(input int waits);
        exp_t e;
        for (int i = 0; i <= waits; i++) begin
            e        = blank(S_FETCH);
            e.srcA   = 1'b1;
            e.srcB   = 2'b10;
            e.resSrc = 2'b10;
            e.irW    = (i == waits);
            e.pcW    = (i == waits);
            applyStimulus(1'b0, i == waits, rnib(), e);
        end
    endtask

    // One whole instruction, expressed as the sequence of cycles it should take.
    task automatic runInstr(input logic [1:0] iop, input logic [5:0] ifn, input logic [3:0] ird,
                            input logic [3:0] icond, input int fWaits, input int mWaits,
                            input logic [3:0] af);
        exp_t       e;
        logic       ce, bad;
        logic [1:0] ctl;
        op    = iop;
        funct = ifn;
        rd    = ird;
        cond  = icond;
        ce    = condHolds(icond, mFlags);
        doFetch(fWaits);
        e      = blank(S_DECODE);
        e.srcA = 1'b1;
        e.srcB = 2'b10;
        e.ill  = (iop == 2'b11);
        applyStimulus(1'b0, rbit(), rnib(), e);
        if (iop == 2'b00) begin
            bad = 1'b0;
            case (ifn[4:1])
                4'b0100: ctl = 2'b00;
                4'b0010: ctl = 2'b01;
                4'b0000: ctl = 2'b10;
                4'b1100: ctl = 2'b11;
                default: begin ctl = 2'b00; bad = 1'b1; end
            endcase
            e        = blank(ifn[5] ? S_EXECI : S_EXECR);
            e.srcB   = ifn[5] ? 2'b01 : 2'b00;
            e.aluCtl = ctl;
            e.ill    = bad;
            applyStimulus(1'b0, rbit(), af, e);
            e      = blank(S_ALUWB);
            e.srcB = ifn[5] ? 2'b01 : 2'b00;
            e.regW = ce && !bad && (ird != 4'd15);
            e.pcW  = ce && !bad && (ird == 4'd15);
            applyStimulus(1'b0, rbit(), rnib(), e);
            if (ce && !bad && ifn[0]) mFlags = af;
        end else if (iop == 2'b01) begin
            e      = blank(S_MEMADR);
            e.srcB = 2'b01;
            applyStimulus(1'b0, rbit(), rnib(), e);
            if (ifn[0]) begin
                for (int i = 0; i <= mWaits; i++) begin
                    e        = blank(S_MEMRD);
                    e.adrSrc = 1'b1;
                    applyStimulus(1'b0, i == mWaits, rnib(), e);
                end
                e        = blank(S_MEMWB);
                e.resSrc = 2'b01;
                e.regW   = ce;
                applyStimulus(1'b0, rbit(), rnib(), e);
            end else if (ce) begin
                for (int i = 0; i <= mWaits; i++) begin
                    e        = blank(S_MEMWR);
                    e.adrSrc = 1'b1;
                    e.memW   = 1'b1;
                    applyStimulus(1'b0, i == mWaits, rnib(), e);
                end
            end else begin
                e        = blank(S_MEMWR);
                e.adrSrc = 1'b1;
                applyStimulus(1'b0, rbit(), rnib(), e);
            end
        end else if (iop == 2'b10) begin
            e        = blank(S_BRANCH);
            e.srcB   = 2'b01;
            e.resSrc = 2'b10;
            e.pcW    = ce;
            applyStimulus(1'b0, rbit(), rnib(), e);
        end
    endtask

    // Store that is aborted by reset while waiting on memory.
    task automatic runStoreAbort();
        exp_t e;
        op    = 2'b01;
        funct = 6'b011000;
        rd    = 4'd3;
        cond  = 4'hE;
        doFetch(0);
        e      = blank(S_DECODE);
        e.srcA = 1'b1;
        e.srcB = 2'b10;
        applyStimulus(1'b0, rbit(), rnib(), e);
        e      = blank(S_MEMADR);
        e.srcB = 2'b01;
        applyStimulus(1'b0, rbit(), rnib(), e);
        e        = blank(S_MEMWR);
        e.adrSrc = 1'b1;
        e.memW   = 1'b1;
        applyStimulus(1'b0, 1'b0, rnib(), e);
        e        = blank(S_MEMWR);
        e.adrSrc = 1'b1;
        applyStimulus(1'b1, 1'b0, rnib(), e);
        mFlags = 4'b0000;
    endtask

    initial begin : monitor
        exp_t m;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                m = expQ.pop_front();
                checkOutput(m);
            end
        end
    end

    initial begin : driver
        exp_t       e;
        int         r;
        logic [1:0] rop;
        logic [5:0] rfn;
        logic [3:0] legalCmds [4];
        legalCmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
        rst       = 1'b1;
        mem_ready = 1'b0;
        op        = 2'b00;
        funct     = 6'd0;
        rd        = 4'd0;
        cond      = 4'hE;
        alu_flags = 4'h0;
        mFlags    = 4'b0000;
        @(posedge clk);
        #1;
        e        = blank(S_FETCH);
        e.srcA   = 1'b1;
        e.srcB   = 2'b10;
        e.resSrc = 2'b10;
        applyStimulus(1'b1, 1'b1, 4'hF, e);

        runInstr(2'b00, 6'b101000, 4'd8, 4'hE, 0, 0, 4'h3);
        runInstr(2'b00, 6'b000101, 4'd8, 4'hE, 0, 0, 4'b0100);
        runInstr(2'b10, 6'b000000, 4'd0, 4'h1, 0, 0, 4'h0);
        runInstr(2'b10, 6'b000000, 4'd0, 4'h0, 0, 0, 4'h0);
        runInstr(2'b01, 6'b011001, 4'd2, 4'hE, 0, 3, 4'h0);
        runInstr(2'b00, 6'b000101, 4'd1, 4'hE, 0, 0, 4'b0000);
        runInstr(2'b01, 6'b011000, 4'd2, 4'h0, 0, 2, 4'h0);
        runInstr(2'b11, 6'b000000, 4'd4, 4'hE, 0, 0, 4'h0);
        runInstr(2'b00, 6'b010101, 4'd5, 4'hE, 0, 0, 4'hF);
        runInstr(2'b00, 6'b000101, 4'd15, 4'hE, 1, 0, 4'hF);
        runStoreAbort();
        runInstr(2'b10, 6'b000000, 4'd0, 4'h0, 0, 0, 4'h0);
        runInstr(2'b10, 6'b000000, 4'd0, 4'h5, 0, 0, 4'h0);

        for (int n = 0; n < 300; n++) begin
            r   = int'($urandom_range(0, 9));
            rfn = 6'($urandom_range(0, 63));
            if (r <= 3) begin
                rop = 2'b00;
                if ($urandom_range(0, 7) != 0) rfn[4:1] = legalCmds[$urandom_range(0, 3)];
            end else if (r <= 6) begin
                rop = 2'b01;
            end else if (r <= 8) begin
                rop = 2'b10;
            end else begin
                rop = 2'b11;
            end
            runInstr(rop, rfn, ($urandom_range(0, 5) == 0) ? 4'd15 : rnib(), rnib(),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rnib());
        end

        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain leftover %0d expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
- Control unit that sequences a multicycle ARM datapath built around a shared instruction/data memory, the register file and one ALU.
- Holds the main FSM, the NZCV flags register and the condition check.
- Decodes the latched instruction fields and drives every datapath enable and mux select.
- Adds a `mem_ready` handshake so memory latency can vary.

Parameters:
- STATE_W, 4, width of the `state_o` debug port (must be at least 4).
- CNT_W, 32, width of the performance counters (only used with ARM_MCTRL_PERF_CNT_EN).

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- mem_ready  in  1  memory has completed the current access this cycle
- op  in  2  instr[27:26]: 00 DP, 01 LDR/STR, 10 B, 11 undefined
- funct  in  6  instr[25:20]: [5] I bit, [4:1] cmd, [0] S/L bit
- rd  in  4  instr[15:12]
- cond  in  4  instr[31:28]
- alu_flags  in  4  ALU NZCV from the current cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register enable
- reg_write  out  1  register file write enable
- result_src  out  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  1  ALU A select: 0 = reg A, 1 = PC
- alu_src_b  out  2  ALU B select: 00 reg B, 01 ExtImm, 10 constant 4
- alu_control  out  2  ALU function: 00 ADD, 01 SUB, 10 AND, 11 ORR
- imm_src  out  2  immediate-extend select; equals `op`, combinational
- reg_src  out  2  [0] = (op==10), [1] = (op==01); combinational
- illegal_instr  out  1  one-cycle pulse on an undefined op or cmd
- state_o  out  STATE_W  current FSM state, for debug

Behaviour:
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9.
- Reset:
  - `rst` is sampled synchronously and sets state to FETCH and flags to 0000.
  - While `rst` is high, all enables (pc_write, mem_write, ir_write, reg_write, illegal_instr) are forced to 0.
  - `rst` asserted in any state aborts the instruction; no write is issued.
- FETCH:
  - Outputs: adr_src=0, alu_src_a=1, alu_src_b=10, ADD, result_src=10.
  - While mem_ready=0: hold in FETCH, ir_write=0, pc_write=0.
  - When mem_ready=1: ir_write=1 and pc_write=1 (PC+4) in that cycle, then go to DECODE.
- DECODE:
  - Outputs: alu_src_a=1, alu_src_b=10, ADD (forms PC+8); register reads occur.
  - Next state: op 01 → MEMADR; op 10 → BRANCH; op 00 with funct[5]=1 → EXECI, else EXECR.
  - op 11 → FETCH with an illegal_instr pulse.
- MEMADR: alu_src_a=0, alu_src_b=01, ADD. funct[0]=1 → MEMRD, else → MEMWR.
- MEMRD: adr_src=1. Hold until mem_ready=1, then → MEMWB.
- MEMWB: result_src=01, reg_write=cond_ex, then → FETCH.
- MEMWR:
  - adr_src=1, mem_write=cond_ex, held for every cycle until mem_ready=1, then → FETCH.
  - When cond_ex=0: go straight to FETCH, no wait.
- EXECR / EXECI:
  - alu_src_a=0; alu_src_b = 00 in EXECR, 01 in EXECI; alu_control decoded from funct[4:1].
  - Decode: 0100 → ADD, 0010 → SUB, 0000 → AND, 1100 → ORR.
  - Any other cmd → ADD, an illegal_instr pulse, and no writes in ALUWB.
  - Both states go to ALUWB.
- ALUWB:
  - result_src=00, reg_write=cond_ex.
  - Flags are loaded from the ALU-out NZCV captured in EXEC, only when funct[0] && cond_ex.
  - If rd==15 && cond_ex: pc_write=1 (PC write), reg_write=0.
  - Then → FETCH.
- BRANCH: alu_src_a=0, alu_src_b=01, ADD, result_src=10, pc_write=cond_ex, then → FETCH.
- cond_ex is evaluated from the flags register (not alu_flags) for all ARM conditions 0000–1110; 1111 → 0.
- Latency without wait states: DP = 4 cycles, LDR = 5, STR = 4, B = 3.
- Write-enable ordering: pc_write and reg_write are never both 1 in one cycle.

Optional Feature:
- Macro: ARM_MCTRL_PERF_CNT_EN.
- When defined:
  - Adds outputs `cycle_cnt` [CNT_W] and `instr_cnt` [CNT_W], both cleared by rst.
  - `cycle_cnt` increments every non-reset cycle.
  - `instr_cnt` increments on entry to FETCH from any non-FETCH state.
  - Both counters wrap modulo 2^CNT_W.
- When undefined: the ports do not exist and no counter logic is built.

Test Plan:
- Reset then ADD R8,R0,#11 (I=1, cond 1110), mem_ready tied 1 → states 0,1,7,8. In ALUWB, reg_write=1 and alu_src_b=01; next instruction fetched at cycle 5.
- SUBS R8,R1,R1 with alu_flags=0100 → flags=0100 after ALUWB. A following BNE (cond 0001) gives pc_write=0 in BRANCH; a BEQ gives pc_write=1.
- LDR with mem_ready low for 3 cycles in MEMRD → stays in state 3 for 4 cycles, reg_write=0 throughout, then MEMWB with reg_write=1 and result_src=01.
- STR with cond 0000 and Z=0 → MEMWR asserts mem_write=0 and returns to FETCH next cycle.
- op=11, then cmd=1010 → each produces exactly one illegal_instr pulse; reg_write, mem_write and pc_write stay 0 outside FETCH.
- rst asserted during MEMWR with mem_ready=0 → next state is FETCH, mem_write=0 during the rst cycle, flags=0000.
